grid_io_tile_cfgbuf: RTL

//  Parametrised successor to the fixed 4-subtile IO grid tile: NUM_IO embedded SoC IO channels on one tile.

---
 rtl/grid_io_tile_cfgbuf_if.sv | 28 ++
 rtl/grid_io_tile_cfgbuf.sv | 63 ++++++
 2 files changed

// File: rtl/grid_io_tile_cfgbuf_if.sv
// grid_io_tile_cfgbuf_if: pad, fabric and scan-chain signals of the IO grid tile
interface grid_io_tile_cfgbuf_if #(
    parameter int NUM_IO = 4
);
    logic              IO_ISOL_N;
    logic [0:NUM_IO-1] gfpga_pad_EMBEDDED_IO_HD_SOC_IN;
    logic [0:NUM_IO-1] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT;
    logic [0:NUM_IO-1] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR;
    logic [0:NUM_IO-1] io_outpad;
    logic [0:NUM_IO-1] io_inpad;
    logic              ccff_head;
    logic              ccff_en;
    logic              cfg_load;
    logic              ccff_tail;
    logic              cfg_ready;
    logic              cfg_overrun;
    logic              cfg_load_err;
    modport master (
        output IO_ISOL_N, gfpga_pad_EMBEDDED_IO_HD_SOC_IN, io_outpad, ccff_head, ccff_en, cfg_load,
        input  gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, io_inpad,
               ccff_tail, cfg_ready, cfg_overrun, cfg_load_err
    );
    modport slave (
        input  IO_ISOL_N, gfpga_pad_EMBEDDED_IO_HD_SOC_IN, io_outpad, ccff_head, ccff_en, cfg_load,
        output gfpga_pad_EMBEDDED_IO_HD_SOC_OUT, gfpga_pad_EMBEDDED_IO_HD_SOC_DIR, io_inpad,
               ccff_tail, cfg_ready, cfg_overrun, cfg_load_err
    );
endinterface

// File: rtl/grid_io_tile_cfgbuf.sv
// grid_io_tile_cfgbuf: NUM_IO-channel embedded IO tile with double-buffered scan configuration
module grid_io_tile_cfgbuf #(
    parameter int NUM_IO = 4,
    parameter int CFG_W  = 2
) (
    input logic                  prog_clk,
    input logic                  pReset,
    grid_io_tile_cfgbuf_if.slave bus
);
    localparam int TOTAL = NUM_IO * CFG_W;
    localparam int CW = $clog2(TOTAL + 1);
    localparam logic [CW-1:0] FULL = CW'(TOTAL);
    logic [TOTAL-1:0]  sr;
    logic [TOTAL-1:0]  active;
    logic [CW-1:0]     cnt;
    logic              overrun;
    logic              load_err;
    logic              ready;
    logic              commit;
    logic [0:NUM_IO-1] dir;
    logic [0:NUM_IO-1] out;
    logic [0:NUM_IO-1] inpad;
    assign ready = (cnt == FULL) && !overrun;
    assign commit = bus.cfg_load && ready;
    assign bus.ccff_tail = sr[TOTAL-1];
    assign bus.cfg_ready = ready;
    assign bus.cfg_overrun = overrun;
    assign bus.cfg_load_err = load_err;
    assign bus.gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = dir;
    assign bus.gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = out;
    assign bus.io_inpad = inpad;
    // shadow chain shift, commit to active bits, chain-length counter and sticky error flags
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            sr       <= '0;
            active   <= '0;
            cnt      <= '0;
            overrun  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            if (bus.ccff_en) sr <= {sr[TOTAL-2:0], bus.ccff_head};
            if (commit) begin
                active <= sr;
                cnt    <= bus.ccff_en ? CW'(1) : '0;
            end else if (bus.ccff_en && cnt != FULL) begin
                cnt <= cnt + CW'(1);
            end
            if (bus.ccff_en && !commit && cnt == FULL) overrun <= 1'b1;
            if (bus.cfg_load && !ready) load_err <= 1'b1;
        end
    end
    // per-channel pad gating: OE selects drive direction, INV flips the inbound data
    always_comb begin
        dir   = '0;
        out   = '0;
        inpad = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            dir[i]   = bus.IO_ISOL_N & active[i*CFG_W];
            out[i]   = bus.IO_ISOL_N & active[i*CFG_W] & bus.io_outpad[i];
            inpad[i] = (bus.IO_ISOL_N & ~active[i*CFG_W] & bus.gfpga_pad_EMBEDDED_IO_HD_SOC_IN[i]) ^ active[i*CFG_W+1];
        end
    end
endmodule
